// File: rtl/vga_fb_reader_if.sv
// Bundle between the scan-out block, the framebuffer RAM read port and the VGA pins.
// master = vga_fb_reader side, slave = RAM / board side.
interface vga_fb_reader_if;
    logic [18:0] read_addr;
    logic        read_data;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    modport master (
        output read_addr,
        input  read_data,
        output hsync,
        output vsync,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input  read_addr,
        output read_data,
        input  hsync,
        input  vsync,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );
endinterface

// File: rtl/vga_fb_reader.sv
// VGA timing generator and 1-bpp framebuffer scan-out; outputs lag the counters by one pixel tick.
// Optional 5x5 red cursor overlay when VGA_FB_READER_CURSOR_EN is defined (adds mouse_x/mouse_y).
module vga_fb_reader #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter logic [11:0] FG_RGB  = 12'hFFF,
    parameter logic [11:0] BG_RGB  = 12'h000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_tick,
`ifdef VGA_FB_READER_CURSOR_EN
    input  logic [9:0]      mouse_x,
    input  logic [9:0]      mouse_y,
`endif
    vga_fb_reader_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    logic [HW-1:0] h_reg, h_next;
    logic [VW-1:0] v_reg, v_next;
    logic [18:0]   addr_reg, addr_next;
    logic          line_end;
    logic          frame_end;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;

    logic          hsync_reg;
    logic          vsync_reg;
    logic [11:0]   rgb_fb_reg;
    logic          frame_start_reg;
    logic [11:0]   rgb_out;

    always_comb begin
        line_end  = (h_reg == HW'(H_TOTAL - 1));
        frame_end = line_end && (v_reg == VW'(V_TOTAL - 1));
        active    = (h_reg < HW'(H_ACTIVE)) && (v_reg < VW'(V_ACTIVE));
        hs_raw    = !((h_reg >= HW'(HS_START)) && (h_reg <= HW'(HS_END)));
        vs_raw    = !((v_reg >= VW'(VS_START)) && (v_reg <= VW'(VS_END)));

        h_next = line_end ? '0 : h_reg + HW'(1);
        v_next = v_reg;
        if (line_end) begin
            v_next = (v_reg == VW'(V_TOTAL - 1)) ? '0 : v_reg + VW'(1);
        end

        // Running pixel count replaces y*H_ACTIVE+x; it parks at the frame size through blanking.
        addr_next = addr_reg;
        if (frame_end) begin
            addr_next = '0;
        end else if (active) begin
            addr_next = addr_reg + 19'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg           <= '0;
            v_reg           <= '0;
            addr_reg        <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            rgb_fb_reg      <= 12'h000;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (pix_tick) begin
                h_reg           <= h_next;
                v_reg           <= v_next;
                addr_reg        <= addr_next;
                hsync_reg       <= hs_raw;
                vsync_reg       <= vs_raw;
                // read_data here answers the address held since the previous tick.
                rgb_fb_reg      <= active ? (bus.read_data ? FG_RGB : BG_RGB) : 12'h000;
                frame_start_reg <= frame_end;
            end
        end
    end

`ifdef VGA_FB_READER_CURSOR_EN
    logic [HW-1:0] h_d_reg;
    logic [VW-1:0] v_d_reg;
    logic [9:0]    mouse_x_reg;
    logic [9:0]    mouse_y_reg;
    logic          active_d_reg;
    logic [10:0]   cur_x, cur_y, ms_x, ms_y;
    logic          cursor_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_d_reg      <= '0;
            v_d_reg      <= '0;
            mouse_x_reg  <= '0;
            mouse_y_reg  <= '0;
            active_d_reg <= 1'b0;
        end else if (pix_tick) begin
            h_d_reg      <= h_reg;
            v_d_reg      <= v_reg;
            mouse_x_reg  <= mouse_x;
            mouse_y_reg  <= mouse_y;
            active_d_reg <= active;
        end
    end

    // One extra bit keeps the +2 window from wrapping near 0 or the top of the range.
    always_comb begin
        cur_x      = 11'(h_d_reg);
        cur_y      = 11'(v_d_reg);
        ms_x       = 11'(mouse_x_reg);
        ms_y       = 11'(mouse_y_reg);
        cursor_hit = active_d_reg
                  && (cur_x + 11'd2 >= ms_x) && (cur_x <= ms_x + 11'd2)
                  && (cur_y + 11'd2 >= ms_y) && (cur_y <= ms_y + 11'd2);
        rgb_out    = cursor_hit ? 12'hF00 : rgb_fb_reg;
    end
`else
    assign rgb_out = rgb_fb_reg;
`endif

    logic [3:0] chan [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = rgb_out[11 - 4*gi -: 4];
        end
    endgenerate

    assign bus.read_addr   = addr_reg;
    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.vga_r       = chan[0];
    assign bus.vga_g       = chan[1];
    assign bus.vga_b       = chan[2];
    assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: a full-size instance and a shrunk-timing instance, both checked every
// clk against a pixel-index model of the raster, plus literal spot checks.
module tb_vga_fb_reader;
    // Small timing: 15 ticks per line, 8 lines per frame, 120 ticks per frame.
    localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 4, S_VFP = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VB;
    localparam int B_HT = 800, B_VT = 525;
    localparam logic [33:0] RST_VAL = {19'd0, 1'b1, 1'b1, 12'h000, 1'b0};

    logic clk = 1'b0;
    logic rst;
    logic pix_tick;
`ifdef VGA_FB_READER_CURSOR_EN
    logic [9:0] mouse_x, mouse_y;
    bit rand_mouse;
`endif

    vga_fb_reader_if bus_b ();
    vga_fb_reader_if bus_s ();

    vga_fb_reader dut_big (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick),
`ifdef VGA_FB_READER_CURSOR_EN
        .mouse_x  (mouse_x),
        .mouse_y  (mouse_y),
`endif
        .bus      (bus_b.master)
    );

    vga_fb_reader #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_small (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick),
`ifdef VGA_FB_READER_CURSOR_EN
        .mouse_x  (mouse_x),
        .mouse_y  (mouse_y),
`endif
        .bus      (bus_s.master)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM: one-clk registered read, shared contents for both instances.
    bit ram [0:524287];
    always @(posedge clk) begin
        bus_b.read_data <= ram[bus_b.read_addr];
        bus_s.read_data <= ram[bus_s.read_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int ticks    = 0;
    bit chk_en   = 0;

    // Pixel-index model: p = ticks since reset modulo frame; counter address = active pixels before p.
    function automatic int addr_at(int p, int ha, int ht, int va);
        int h, v;
        h = p % ht;
        v = p / ht;
        if (v < va) return v * ha + ((h < ha) ? h : ha);
        return va * ha;
    endfunction

    function automatic logic [33:0] model_out(int p, int ha, int hfp, int hsw, int ht,
                                              int va, int vfp, int vsw, int vt);
        int h, v, nxt;
        bit act, hs, vs, fs;
        logic [11:0] rgb;
        h   = p % ht;
        v   = p / ht;
        act = (h < ha) && (v < va);
        rgb = act ? (ram[addr_at(p, ha, ht, va)] ? 12'hFFF : 12'h000) : 12'h000;
`ifdef VGA_FB_READER_CURSOR_EN
        if (act && (h - int'(mouse_x) <= 2) && (int'(mouse_x) - h <= 2)
                && (v - int'(mouse_y) <= 2) && (int'(mouse_y) - v <= 2))
            rgb = 12'hF00;
`endif
        hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
        vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
        fs  = (p == ht * vt - 1);
        nxt = (p + 1) % (ht * vt);
        return {19'(addr_at(nxt, ha, ht, va)), hs, vs, rgb, fs};
    endfunction

    logic [33:0] exp_b, exp_s;
    int cnt_b, cnt_s;
    always @(posedge clk) begin
        if (rst) begin
            exp_b = RST_VAL; exp_s = RST_VAL; cnt_b = 0; cnt_s = 0;
        end else if (pix_tick) begin
            exp_b = model_out(cnt_b, 640, 16, 96, B_HT, 480, 10, 2, B_VT);
            exp_s = model_out(cnt_s, S_HA, S_HFP, S_HS, S_HT, S_VA, S_VFP, S_VS, S_VT);
            cnt_b = (cnt_b + 1) % (B_HT * B_VT);
            cnt_s = (cnt_s + 1) % (S_HT * S_VT);
        end else begin
            exp_b[0] = 1'b0;
            exp_s[0] = 1'b0;
        end
    end

    wire [33:0] act_b = {bus_b.read_addr, bus_b.hsync, bus_b.vsync,
                         bus_b.vga_r, bus_b.vga_g, bus_b.vga_b, bus_b.frame_start};
    wire [33:0] act_s = {bus_s.read_addr, bus_s.hsync, bus_s.vsync,
                         bus_s.vga_r, bus_s.vga_g, bus_s.vga_b, bus_s.frame_start};

    task automatic check_bus(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got addr=%0d hs=%b vs=%b rgb=%h fs=%b, expected addr=%0d hs=%b vs=%b rgb=%h fs=%b",
                     name, $time, act[33:15], act[14], act[13], act[12:1], act[0],
                     exp[33:15], exp[14], exp[13], exp[12:1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_bus("big_model", act_b, exp_b);
            check_bus("small_model", act_s, exp_s);
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick_edge();
`ifdef VGA_FB_READER_CURSOR_EN
        if (rand_mouse) begin
            mouse_x = 10'($urandom_range(0, 9));
            mouse_y = 10'($urandom_range(0, 5));
        end
`endif
        pix_tick = 1'b1;
        @(posedge clk); #1;
        pix_tick = 1'b0;
        ticks++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; pix_tick = 1'b0;
        idle(n);
        rst = 1'b0;
        ticks = 0;
    endtask

    function automatic int rgb_b();
        return int'({bus_b.vga_r, bus_b.vga_g, bus_b.vga_b});
    endfunction

    function automatic int rgb_s();
        return int'({bus_s.vga_r, bus_s.vga_g, bus_s.vga_b});
    endfunction

    initial begin
        rst = 1'b1; pix_tick = 1'b0;
`ifdef VGA_FB_READER_CURSOR_EN
        mouse_x = 10'd300; mouse_y = 10'd300; rand_mouse = 0;
`endif
        for (int i = 0; i <= 307200; i++) ram[i] = 1'($urandom);
        ram[0] = 1'b1; ram[1] = 1'b0; ram[307200] = 1'b1; ram[S_VA * S_HA] = 1'b1;

        // Reset held 3 clk with ticks toggling.
        @(posedge clk); #1; chk_en = 1;
        repeat (3) begin pix_tick = ~pix_tick; @(posedge clk); #1; end
        pix_tick = 1'b0;
        check_lit("rst_addr", int'(bus_b.read_addr), 0);
        check_lit("rst_hsync", int'(bus_b.hsync), 1);
        check_lit("rst_vsync", int'(bus_b.vsync), 1);
        check_lit("rst_rgb", rgb_b(), 0);
        check_lit("rst_fs", int'(bus_b.frame_start), 0);
        rst = 1'b0;
        check_lit("first_addr", int'(bus_b.read_addr), 0);

        // Alignment: ticks every 4 clk, pixel 0 is lit, pixel 1 is dark.
        tick_edge(); check_lit("align_px0_rgb", rgb_b(), 12'hFFF);
        check_lit("align_addr1", int'(bus_b.read_addr), 1); idle(3);
        tick_edge(); check_lit("align_px1_rgb", rgb_b(), 12'h000); idle(3);

        // First two lines of the full-size raster, random tick spacing and one 10-clk pause.
        while (ticks < 1700) begin
            tick_edge();
            case (ticks)
                639:  check_lit("addr_h639_v0", int'(bus_b.read_addr), 639);
                640:  check_lit("addr_hblank_v0", int'(bus_b.read_addr), 640);
                656:  check_lit("hsync_before", int'(bus_b.hsync), 1);
                657:  check_lit("hsync_first_low", int'(bus_b.hsync), 0);
                752:  check_lit("hsync_last_low", int'(bus_b.hsync), 0);
                753:  check_lit("hsync_release", int'(bus_b.hsync), 1);
                800:  check_lit("addr_h0_v1", int'(bus_b.read_addr), 640);
                1440: check_lit("addr_hblank_v1", int'(bus_b.read_addr), 1280);
                default: ;
            endcase
            if (ticks == 900) idle(10);
            else idle($urandom_range(1, 3));
        end

        // Mid-frame reset, then several frames of the small raster.
        do_reset(2);
        while (ticks < 400) begin
            tick_edge();
            case (ticks)
                31:  check_lit("s_addr_x1_y2", int'(bus_s.read_addr), 17);
                75:  check_lit("s_vsync_before", int'(bus_s.vsync), 1);
                76:  check_lit("s_vsync_first_low", int'(bus_s.vsync), 0);
                105: check_lit("s_vsync_last_low", int'(bus_s.vsync), 0);
                106: check_lit("s_vsync_release", int'(bus_s.vsync), 1);
                119: check_lit("s_addr_vblank", int'(bus_s.read_addr), S_VA * S_HA);
                120: begin
                    check_lit("s_frame_start", int'(bus_s.frame_start), 1);
                    check_lit("s_addr_wrap", int'(bus_s.read_addr), 0);
                end
                240: check_lit("s_frame_start2", int'(bus_s.frame_start), 1);
                default: ;
            endcase
            idle($urandom_range(1, 2));
        end

`ifdef VGA_FB_READER_CURSOR_EN
        // Cursor at the origin must not wrap; then at the small raster's bottom-right corner.
        ram[3] = 1'b0; ram[24] = 1'b0;
        mouse_x = 10'd0; mouse_y = 10'd0;
        do_reset(2);
        while (ticks < 60) begin
            tick_edge();
            case (ticks)
                1: check_lit("cur_px0_0", rgb_b(), 12'hF00);
                3: check_lit("cur_px2_0", rgb_b(), 12'hF00);
                4: begin
                    check_lit("cur_px3_0", rgb_b(), 12'h000);
                    mouse_x = 10'd7; mouse_y = 10'd3;
                end
                46: check_lit("s_cur_px0_3", rgb_s(), 12'h000);
                53: check_lit("s_cur_px7_3", rgb_s(), 12'hF00);
                default: ;
            endcase
            idle($urandom_range(1, 2));
        end
        rand_mouse = 1;
        while (ticks < 360) begin
            tick_edge();
            idle($urandom_range(1, 2));
        end
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
